// File: rtl/alu_step_sequencer_if.sv
// rtl/alu_step_sequencer_if.sv - control bus between the step sequencer and the Mini SRC datapath
interface alu_step_sequencer_if #(
  parameter int NUM_REGS = 16
);
  logic                start;
  logic                mem_rdy;
  logic [31:0]         ir;
  logic                Pout;
  logic                MARen;
  logic                Pen;
  logic                Read;
  logic                MDRen;
  logic                MDROut;
  logic                IRen;
  logic                Yen;
  logic                ZLOen;
  logic                ZHIen;
  logic                ZLOout;
  logic                ZHIout;
  logic                HIen;
  logic                LOen;
  logic [NUM_REGS-1:0] R_out;
  logic [NUM_REGS-1:0] R_en;
  logic [4:0]          alu_control;
  logic                done;
  logic                illegal;
  logic                mem_fault;

  // Sequencer side: consumes IR / handshake, drives every strobe.
  modport master (
    input  start, mem_rdy, ir,
    output Pout, MARen, Pen, Read, MDRen, MDROut, IRen, Yen,
    output ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen,
    output R_out, R_en, alu_control, done, illegal, mem_fault
  );

  // Datapath side.
  modport slave (
    output start, mem_rdy, ir,
    input  Pout, MARen, Pen, Read, MDRen, MDROut, IRen, Yen,
    input  ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen,
    input  R_out, R_en, alu_control, done, illegal, mem_fault
  );
endinterface

// File: rtl/alu_step_sequencer.sv
// rtl/alu_step_sequencer.sv - fetch/execute control-step sequencer for Mini SRC ALU instructions
module alu_step_sequencer #(
  parameter int         NUM_REGS    = 16,
  parameter logic [4:0] INC_OP      = 5'b11111,
  parameter int         MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 clr,
  alu_step_sequencer_if.master bus
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T1W  = 4'd3;
  localparam logic [3:0] S_T2   = 4'd4;
  localparam logic [3:0] S_T3   = 4'd5;
  localparam logic [3:0] S_T4   = 4'd6;
  localparam logic [3:0] S_T5   = 4'd7;
  localparam logic [3:0] S_T6   = 4'd8;
  localparam logic [3:0] S_ERR  = 4'd9;

  localparam int            CW        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          illegal_q, illegal_d;
  logic          fault_q, fault_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_a, is_m, is_u, bad_dec;
  logic [3:0] after_done;
  logic       unused_ir;

  assign op        = bus.ir[31:27];
  assign ra        = bus.ir[26:23];
  assign rb        = bus.ir[22:19];
  assign rc        = bus.ir[18:15];
  assign unused_ir = ^bus.ir[14:0];

  assign is_a    = (op >= 5'd3) && (op <= 5'd11);
  assign is_m    = (op == 5'd15) || (op == 5'd16);
  assign is_u    = (op == 5'd17) || (op == 5'd18);
  // rc is only a source for the 3-register class, so only check it there.
  assign bad_dec = !(is_a || is_m || is_u)
                || (int'(ra) >= NUM_REGS) || (int'(rb) >= NUM_REGS)
                || (is_a && (int'(rc) >= NUM_REGS));

  // Holding start through the final step chains straight into the next fetch.
  assign after_done = bus.start ? S_T0 : S_IDLE;

  assign bus.illegal   = illegal_q;
  assign bus.mem_fault = fault_q;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

  // State, wait counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
    end
  end

  // Next-state: fetch with variable-latency read, then class-specific execute.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    fault_d   = fault_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1: begin
        wait_d  = '0;
        state_d = bus.mem_rdy ? S_T2 : S_T1W;
      end
      S_T1W: begin
        if (bus.mem_rdy) begin
          state_d = S_T2;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (bad_dec) begin
          state_d   = S_ERR;
          illegal_d = 1'b1;
        end else begin
          state_d = S_T4;
        end
      end
      S_T4:   state_d = is_u ? after_done : S_T5;
      S_T5:   state_d = is_a ? after_done : S_T6;
      S_T6:   state_d = after_done;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe decode; everything defaults low so IDLE/ERR drive nothing.
  always_comb begin
    bus.Pout        = 1'b0;
    bus.MARen       = 1'b0;
    bus.Pen         = 1'b0;
    bus.Read        = 1'b0;
    bus.MDRen       = 1'b0;
    bus.MDROut      = 1'b0;
    bus.IRen        = 1'b0;
    bus.Yen         = 1'b0;
    bus.ZLOen       = 1'b0;
    bus.ZHIen       = 1'b0;
    bus.ZLOout      = 1'b0;
    bus.ZHIout      = 1'b0;
    bus.HIen        = 1'b0;
    bus.LOen        = 1'b0;
    bus.R_out       = '0;
    bus.R_en        = '0;
    bus.alu_control = 5'd0;
    bus.done        = 1'b0;
    case (state_q)
      S_T0: begin
        bus.Pout        = 1'b1;
        bus.MARen       = 1'b1;
        bus.ZLOen       = 1'b1;
        bus.alu_control = INC_OP;
      end
      S_T1: begin
        bus.ZLOout = 1'b1;
        bus.Pen    = 1'b1;
        bus.Read   = 1'b1;
        bus.MDRen  = bus.mem_rdy;
      end
      S_T1W: begin
        bus.Read  = 1'b1;
        bus.MDRen = bus.mem_rdy;
      end
      S_T2: begin
        bus.MDROut = 1'b1;
        bus.IRen   = 1'b1;
      end
      S_T3: begin
        if (!bad_dec) begin
          if (is_u) begin
            bus.R_out       = onehot(rb);
            bus.ZLOen       = 1'b1;
            bus.alu_control = op;
          end else begin
            bus.R_out = onehot(is_m ? ra : rb);
            bus.Yen   = 1'b1;
          end
        end
      end
      S_T4: begin
        if (is_u) begin
          bus.ZLOout = 1'b1;
          bus.R_en   = onehot(ra);
          bus.done   = 1'b1;
        end else begin
          bus.R_out       = onehot(is_m ? rb : rc);
          bus.alu_control = op;
          bus.ZLOen       = 1'b1;
          bus.ZHIen       = is_m;
        end
      end
      S_T5: begin
        bus.ZLOout = 1'b1;
        if (is_a) begin
          bus.R_en = onehot(ra);
          bus.done = 1'b1;
        end else begin
          bus.LOen = 1'b1;
        end
      end
      S_T6: begin
        bus.ZHIout = 1'b1;
        bus.HIen   = 1'b1;
        bus.done   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_step_sequencer.sv
// tb/tb_alu_step_sequencer.sv - directed self-checking bench for alu_step_sequencer
module tb_alu_step_sequencer;

  logic clk = 1'b0;
  logic clr;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_step_sequencer_if #(.NUM_REGS(16)) bus16 ();
  alu_step_sequencer_if #(.NUM_REGS(8))  bus8 ();

  alu_step_sequencer #(.NUM_REGS(16), .INC_OP(5'b11111), .MEM_TIMEOUT(15)) dut16 (
    .clk(clk), .clr(clr), .bus(bus16)
  );
  alu_step_sequencer #(.NUM_REGS(8), .INC_OP(5'b11111), .MEM_TIMEOUT(15)) dut8 (
    .clk(clk), .clr(clr), .bus(bus8)
  );

  // Strobe vector bit masks, MSB first: Pout..LOen.
  localparam logic [13:0] S_POUT   = 14'h2000;
  localparam logic [13:0] S_MAREN  = 14'h1000;
  localparam logic [13:0] S_PEN    = 14'h0800;
  localparam logic [13:0] S_READ   = 14'h0400;
  localparam logic [13:0] S_MDREN  = 14'h0200;
  localparam logic [13:0] S_MDROUT = 14'h0100;
  localparam logic [13:0] S_IREN   = 14'h0080;
  localparam logic [13:0] S_YEN    = 14'h0040;
  localparam logic [13:0] S_ZLOEN  = 14'h0020;
  localparam logic [13:0] S_ZHIEN  = 14'h0010;
  localparam logic [13:0] S_ZLOOUT = 14'h0008;
  localparam logic [13:0] S_ZHIOUT = 14'h0004;
  localparam logic [13:0] S_HIEN   = 14'h0002;
  localparam logic [13:0] S_LOEN   = 14'h0001;
  localparam logic [15:0] Z16      = 16'h0000;

  localparam logic [51:0] E_T0   = {S_POUT | S_MAREN | S_ZLOEN, Z16, Z16, 5'b11111, 1'b0};
  localparam logic [51:0] E_T1R  = {S_ZLOOUT | S_PEN | S_READ | S_MDREN, Z16, Z16, 5'b0, 1'b0};
  localparam logic [51:0] E_T1N  = {S_ZLOOUT | S_PEN | S_READ, Z16, Z16, 5'b0, 1'b0};
  localparam logic [51:0] E_T1W  = {S_READ, Z16, Z16, 5'b0, 1'b0};
  localparam logic [51:0] E_T1WR = {S_READ | S_MDREN, Z16, Z16, 5'b0, 1'b0};
  localparam logic [51:0] E_T2   = {S_MDROUT | S_IREN, Z16, Z16, 5'b0, 1'b0};
  localparam logic [51:0] E_ZERO = 52'h0;
  // and R1,R2,R3
  localparam logic [51:0] E_A3   = {S_YEN, 16'h0004, Z16, 5'b0, 1'b0};
  localparam logic [51:0] E_A4   = {S_ZLOEN, 16'h0008, Z16, 5'b00101, 1'b0};
  localparam logic [51:0] E_A5   = {S_ZLOOUT, Z16, 16'h0002, 5'b0, 1'b1};

  function automatic logic [51:0] pack16();
    return {bus16.Pout, bus16.MARen, bus16.Pen, bus16.Read, bus16.MDRen, bus16.MDROut,
            bus16.IRen, bus16.Yen, bus16.ZLOen, bus16.ZHIen, bus16.ZLOout, bus16.ZHIout,
            bus16.HIen, bus16.LOen, bus16.R_out, bus16.R_en, bus16.alu_control, bus16.done};
  endfunction

  task automatic test_reset();
    logic [51:0] obs;
    clr = 1'b1;
    bus16.start = 1'b1; bus16.mem_rdy = 1'b1; bus16.ir = 32'h28918000;
    bus8.start  = 1'b0; bus8.mem_rdy  = 1'b1; bus8.ir  = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    obs = pack16();
    n_checks++;
    if (obs !== E_ZERO) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, E_ZERO);
    end
    n_checks++;
    if ({bus16.illegal, bus16.mem_fault} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00", {bus16.illegal, bus16.mem_fault});
    end
    clr = 1'b0; bus16.start = 1'b0;
    @(negedge clk); #1;
    obs = pack16();
    n_checks++;
    if (obs !== E_ZERO) begin
      n_fail++; $display("FAIL reset_idle_hold: got %h expected %h", obs, E_ZERO);
    end
  endtask

  task automatic test_class_a();
    logic [51:0] exp [7];
    logic [51:0] obs;
    exp = '{E_T0, E_T1R, E_T2, E_A3, E_A4, E_A5, E_ZERO};
    @(negedge clk);
    bus16.ir = 32'h28918000; bus16.mem_rdy = 1'b1; bus16.start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus16.start = 1'b0;
      #1;
      obs = pack16();
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++; $display("FAIL class_a step %0d: got %h expected %h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [51:0] exp [11];
    logic        mr  [11];
    logic [51:0] obs;
    int          pen_cnt = 0;
    exp = '{E_T0, E_T1N, E_T1W, E_T1W, E_T1W, E_T1WR, E_T2, E_A3, E_A4, E_A5, E_ZERO};
    mr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    @(negedge clk);
    bus16.ir = 32'h28918000; bus16.start = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus16.start = 1'b0; bus16.mem_rdy = mr[i];
      #1;
      obs = pack16();
      pen_cnt += int'(bus16.Pen);
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++; $display("FAIL mem_wait step %0d: got %h expected %h", i, obs, exp[i]);
      end
    end
    n_checks++;
    if (pen_cnt !== 1) begin
      n_fail++; $display("FAIL mem_wait_pen_once: got %0d expected 1", pen_cnt);
    end
  endtask

  task automatic test_mem_timeout();
    logic [51:0] obs;
    logic [51:0] e;
    @(negedge clk);
    bus16.ir = 32'h28918000; bus16.mem_rdy = 1'b0; bus16.start = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus16.start = 1'b0;
      #1;
      e = (i == 0) ? E_T0 : (i == 1) ? E_T1N : E_T1W;
      obs = pack16();
      n_checks++;
      if (obs !== e || bus16.mem_fault !== 1'b0) begin
        n_fail++; $display("FAIL timeout_wait step %0d: got %h/%b expected %h/0", i, obs, bus16.mem_fault, e);
      end
    end
    bus16.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      obs = pack16();
      n_checks++;
      if (obs !== E_ZERO || bus16.mem_fault !== 1'b1) begin
        n_fail++; $display("FAIL timeout_err cycle %0d: got %h/%b expected %h/1", i, obs, bus16.mem_fault, E_ZERO);
      end
    end
    clr = 1'b1; bus16.start = 1'b0;
    @(negedge clk);
    clr = 1'b0; bus16.mem_rdy = 1'b1;
    #1;
    obs = pack16();
    n_checks++;
    if (obs !== E_ZERO || bus16.mem_fault !== 1'b0) begin
      n_fail++; $display("FAIL timeout_clear: got %h/%b expected %h/0", obs, bus16.mem_fault, E_ZERO);
    end
  endtask

  task automatic test_class_m();
    logic [51:0] exp [8];
    logic [51:0] obs;
    exp = '{E_T0, E_T1R, E_T2,
            {S_YEN, 16'h0010, Z16, 5'b0, 1'b0},
            {S_ZLOEN | S_ZHIEN, 16'h0020, Z16, 5'b01111, 1'b0},
            {S_ZLOOUT | S_LOEN, Z16, Z16, 5'b0, 1'b0},
            {S_ZHIOUT | S_HIEN, Z16, Z16, 5'b0, 1'b1},
            E_ZERO};
    @(negedge clk);
    bus16.ir = 32'h7A280000; bus16.mem_rdy = 1'b1; bus16.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus16.start = 1'b0;
      #1;
      obs = pack16();
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++; $display("FAIL class_m step %0d: got %h expected %h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_class_u();
    logic [51:0] exp [6];
    logic [51:0] obs;
    // neg R6,R7
    exp = '{E_T0, E_T1R, E_T2,
            {S_ZLOEN, 16'h0080, Z16, 5'b10001, 1'b0},
            {S_ZLOOUT, Z16, 16'h0040, 5'b0, 1'b1},
            E_ZERO};
    @(negedge clk);
    bus16.ir = {5'b10001, 4'd6, 4'd7, 19'd0}; bus16.mem_rdy = 1'b1; bus16.start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus16.start = 1'b0;
      #1;
      obs = pack16();
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++; $display("FAIL class_u step %0d: got %h expected %h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_illegal_op();
    logic [51:0] exp [6];
    logic [51:0] obs;
    logic [15:0] ren_acc = '0;
    exp = '{E_T0, E_T1R, E_T2, E_ZERO, E_ZERO, E_ZERO};
    @(negedge clk);
    bus16.ir = 32'h00000000; bus16.mem_rdy = 1'b1; bus16.start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      obs = pack16();
      ren_acc |= bus16.R_en;
      n_checks++;
      if (obs !== exp[i] || bus16.illegal !== (i >= 4)) begin
        n_fail++; $display("FAIL illegal_op step %0d: got %h/%b expected %h/%b", i, obs, bus16.illegal, exp[i], i >= 4);
      end
    end
    n_checks++;
    if (ren_acc !== 16'h0) begin
      n_fail++; $display("FAIL illegal_op_ren: got %h expected 0000", ren_acc);
    end
    clr = 1'b1; bus16.start = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    #1;
    n_checks++;
    if (bus16.illegal !== 1'b0) begin
      n_fail++; $display("FAIL illegal_clear: got %b expected 0", bus16.illegal);
    end
  endtask

  task automatic test_illegal_field();
    logic [7:0] ren_acc = '0;
    logic [7:0] rout_t3 = '0;
    @(negedge clk);
    bus8.ir = {5'b00011, 4'd1, 4'd2, 4'd9, 15'd0}; bus8.mem_rdy = 1'b1; bus8.start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus8.start = 1'b0;
      #1;
      ren_acc |= bus8.R_en;
      if (i == 3) rout_t3 = bus8.R_out;
    end
    n_checks++;
    if (bus8.illegal !== 1'b1) begin
      n_fail++; $display("FAIL illegal_rc9: got %b expected 1", bus8.illegal);
    end
    n_checks++;
    if ({ren_acc, rout_t3} !== 16'h0) begin
      n_fail++; $display("FAIL illegal_rc9_regs: got %h expected 0000", {ren_acc, rout_t3});
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [51:0] exp [13];
    logic [51:0] obs;
    exp = '{E_T0, E_T1R, E_T2, E_A3, E_A4, E_A5,
            E_T0, E_T1R, E_T2, E_A3, E_A4, E_A5, E_ZERO};
    @(negedge clk);
    bus16.ir = 32'h28918000; bus16.mem_rdy = 1'b1; bus16.start = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bus16.start = (i <= 5);
      #1;
      obs = pack16();
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++; $display("FAIL back_to_back step %0d: got %h expected %h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [51:0] exp [5];
    logic [51:0] obs;
    logic [15:0] ren_acc = '0;
    exp = '{E_T0, E_T1R, E_T2, E_A3, E_A4};
    @(negedge clk);
    bus16.ir = 32'h28918000; bus16.mem_rdy = 1'b1; bus16.start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus16.start = 1'b0;
      clr = (i == 4);
      #1;
      obs = pack16();
      ren_acc |= bus16.R_en;
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++; $display("FAIL reset_mid step %0d: got %h expected %h", i, obs, exp[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clr = 1'b0;
      #1;
      obs = pack16();
      ren_acc |= bus16.R_en;
      n_checks++;
      if (obs !== E_ZERO) begin
        n_fail++; $display("FAIL reset_mid_idle cycle %0d: got %h expected %h", i, obs, E_ZERO);
      end
    end
    n_checks++;
    if (ren_acc !== 16'h0) begin
      n_fail++; $display("FAIL reset_mid_ren: got %h expected 0000", ren_acc);
    end
  endtask

  initial begin
    test_reset();
    test_class_a();
    test_mem_wait();
    test_mem_timeout();
    test_class_m();
    test_class_u();
    test_illegal_op();
    test_illegal_field();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
